axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: NIN requesters share one registered
// output stream, each granted up to BURST words before rotation.
module axis_rr_arbiter #(
  parameter  int DWIDTH = 32,
  parameter  int NIN    = 2,
  parameter  int BURST  = 4,
  localparam int IDW    = (NIN > 1) ? $clog2(NIN) : 1,
  localparam int CW     = $clog2(BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NIN*DWIDTH-1:0] s_din_tdata,
  input  logic [NIN-1:0]        s_din_tvalid,
  output logic [NIN-1:0]        s_din_tready,
  output logic [DWIDTH-1:0]     m_dout_tdata,
  output logic [IDW-1:0]        m_dout_tid,
  output logic                  m_dout_tvalid,
  input  logic                  m_dout_tready
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    gnt, gnt_n;
  logic [IDW-1:0]    ptr, ptr_n;
  logic [IDW-1:0]    pick, gnt_inc, scan;
  logic [CW-1:0]     cnt, cnt_n;
  logic              accept, xfer, found, sel_valid;
  logic [DWIDTH-1:0] sel_data;

  assign accept  = !m_dout_tvalid || m_dout_tready;
  assign gnt_inc = (gnt == IDW'(NIN - 1)) ? '0 : gnt + IDW'(1);
  assign xfer    = rst && (state == GRANT) && accept && sel_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NIN; i++) begin
      if (gnt == IDW'(i)) begin
        sel_valid = s_din_tvalid[i];
        sel_data  = s_din_tdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    s_din_tready = '0;
    for (int i = 0; i < NIN; i++) begin
      s_din_tready[i] = rst && (state == GRANT)
                        && accept && (gnt == IDW'(i));
    end
  end

  // Rotating search starting at ptr; wrap is explicit for any NIN.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    scan  = ptr;
    for (int k = 0; k < NIN; k++) begin
      for (int j = 0; j < NIN; j++) begin
        if (!found && scan == IDW'(j) && s_din_tvalid[j]) begin
          found = 1'b1;
          pick  = scan;
        end
      end
      scan = (scan == IDW'(NIN - 1)) ? '0 : scan + IDW'(1);
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = pick;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_n = cnt + CW'(1);
          if (cnt + CW'(1) == CW'(BURST)) begin
            state_n = IDLE;
            ptr_n   = gnt_inc;
          end
        end else if (accept) begin
          state_n = IDLE;
          ptr_n   = gnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_dout_tvalid <= 1'b0;
      m_dout_tdata  <= '0;
      m_dout_tid    <= '0;
    end else if (xfer) begin
      m_dout_tvalid <= 1'b1;
      m_dout_tdata  <= sel_data;
      m_dout_tid    <= gnt;
    end else if (accept) begin
      m_dout_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: NIN=2/BURST=4 instance plus
// a NIN=3/BURST=1 instance for index wrap.
module tb_axis_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_tdata;
  logic [1:0]  a_tvalid, a_tready;
  logic [31:0] a_mdata;
  logic [0:0]  a_mid;
  logic        a_mvalid, a_mready;

  logic [95:0] b_tdata;
  logic [2:0]  b_tvalid, b_tready;
  logic [31:0] b_mdata;
  logic [1:0]  b_mid;
  logic        b_mvalid, b_mready;

  axis_rr_arbiter #(.DWIDTH(32), .NIN(2), .BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .s_din_tdata(a_tdata), .s_din_tvalid(a_tvalid),
    .s_din_tready(a_tready),
    .m_dout_tdata(a_mdata), .m_dout_tid(a_mid),
    .m_dout_tvalid(a_mvalid), .m_dout_tready(a_mready)
  );

  axis_rr_arbiter #(.DWIDTH(32), .NIN(3), .BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .s_din_tdata(b_tdata), .s_din_tvalid(b_tvalid),
    .s_din_tready(b_tready),
    .m_dout_tdata(b_mdata), .m_dout_tid(b_mid),
    .m_dout_tvalid(b_mvalid), .m_dout_tready(b_mready)
  );

  int          total = 0;
  int          bad   = 0;
  int          idx[2];
  int          lim[2];
  logic [31:0] base[2];
  bit          en[2];
  bit          fx[2];
  int          tab[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Requester i presents base+idx while idx<lim, advancing on transfer.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      a_tvalid[i] = en[i] && (idx[i] < lim[i]);
      a_tdata[i*32 +: 32] = base[i] + 32'(idx[i]);
    end
  endtask

  task automatic cyc();
    drive();
    #1;
    for (int i = 0; i < 2; i++) fx[i] = a_tvalid[i] && a_tready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (fx[i]) idx[i]++;
    drive();
    @(negedge clk);
  endtask

  // e < 0 means no valid word; else e = (tid << 8) | data.
  task automatic chk_o(string tag, int e, logic v,
                       logic [31:0] d, logic [31:0] id);
    if (e < 0) begin
      chk({tag, "_v"}, 32'(v), 32'd0);
    end else begin
      chk({tag, "_v"}, 32'(v), 32'd1);
      chk({tag, "_d"}, d, 32'(e & 255));
      chk({tag, "_id"}, id, 32'(e >> 8));
    end
  endtask

  task automatic run_tab(string tag, bit useb);
    for (int i = 0; i < tab.size(); i++) begin
      cyc();
      if (useb)
        chk_o($sformatf("%s%0d", tag, i), tab[i],
              b_mvalid, b_mdata, 32'(b_mid));
      else
        chk_o($sformatf("%s%0d", tag, i), tab[i],
              a_mvalid, a_mdata, 32'(a_mid));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i]  = 1'b0;
      idx[i] = 0;
      lim[i] = 0;
      base[i] = '0;
    end
    b_tvalid = '0;
    a_mready = 1'b1;
    b_mready = 1'b1;
    repeat (2) cyc();
    chk("rst_av", 32'(a_mvalid), 32'd0);
    chk("rst_ad", a_mdata, 32'd0);
    chk("rst_aid", 32'(a_mid), 32'd0);
    chk("rst_ardy", 32'(a_tready), 32'd0);
    chk("rst_bv", 32'(b_mvalid), 32'd0);
    chk("rst_brdy", 32'(b_tready), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    a_tdata = '0;
    a_tvalid = '0;
    a_mready = 1'b1;
    b_tdata = {32'd2, 32'd1, 32'd0};
    b_tvalid = '0;
    b_mready = 1'b1;
    @(negedge clk);

    // single requester, latency and burst bubble
    do_reset();
    base[1] = 32'hA0;
    lim[1] = 6;
    en[1] = 1'b1;
    cyc();
    chk("t1_arb_v", 32'(a_mvalid), 32'd0);
    chk("t1_rdy", 32'(a_tready), 32'd2);
    tab = '{'h1A0, 'h1A1, 'h1A2, 'h1A3, -1, 'h1A4, 'h1A5, -1};
    run_tab("t1_", 1'b0);

    // contention between both requesters
    do_reset();
    base[0] = 32'h00;
    base[1] = 32'h10;
    lim[0] = 12;
    lim[1] = 12;
    en[0] = 1'b1;
    en[1] = 1'b1;
    tab = '{-1, 'h000, 'h001, 'h002, 'h003, -1,
            'h110, 'h111, 'h112, 'h113, -1,
            'h004, 'h005, 'h006, 'h007};
    run_tab("t2_", 1'b0);

    // downstream backpressure on the second word
    do_reset();
    base[0] = 32'h30;
    lim[0] = 4;
    en[0] = 1'b1;
    tab = '{-1, 'h030, 'h031};
    run_tab("t3a_", 1'b0);
    a_mready = 1'b0;
    #1;
    chk("t3_rdy0", 32'(a_tready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_o($sformatf("t3_hold%0d", k), 'h031,
            a_mvalid, a_mdata, 32'(a_mid));
      chk($sformatf("t3_rdy%0d", k), 32'(a_tready), 32'd0);
    end
    a_mready = 1'b1;
    tab = '{'h032, 'h033, -1};
    run_tab("t3b_", 1'b0);

    // early release by req0, later req0 waits for req1 burst
    do_reset();
    base[0] = 32'h40;
    lim[0] = 2;
    base[1] = 32'h50;
    lim[1] = 4;
    en[0] = 1'b1;
    en[1] = 1'b1;
    tab = '{-1, 'h040, 'h041};
    run_tab("t4a_", 1'b0);
    cyc();
    chk("t4_idle_v", 32'(a_mvalid), 32'd0);
    chk("t4_idle_rdy", 32'(a_tready), 32'd0);
    cyc();
    chk("t4_g1_v", 32'(a_mvalid), 32'd0);
    chk("t4_g1_rdy", 32'(a_tready), 32'd2);
    lim[0] = 4;
    tab = '{'h150, 'h151, 'h152, 'h153, -1, 'h042, 'h043, -1};
    run_tab("t4b_", 1'b0);

    // NIN=3, BURST=1 index wrap
    do_reset();
    b_tvalid = 3'b111;
    tab = '{-1, 'h000, -1, 'h101, -1, 'h202,
            -1, 'h000, -1, 'h101, -1, 'h202};
    run_tab("t5_", 1'b1);
    b_tvalid = '0;

    // reset while a word is stalled in the output register
    do_reset();
    base[0] = 32'h60;
    base[1] = 32'h70;
    lim[0] = 8;
    lim[1] = 8;
    en[0] = 1'b1;
    en[1] = 1'b1;
    tab = '{-1, 'h060, 'h061, 'h062, 'h063, -1, 'h170, 'h171};
    run_tab("t6_", 1'b0);
    a_mready = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_inrst_rdy", 32'(a_tready), 32'd0);
    chk("t6_inrst_v", 32'(a_mvalid), 32'd1);
    cyc();
    chk("t6_post_v", 32'(a_mvalid), 32'd0);
    chk("t6_post_rdy", 32'(a_tready), 32'd0);
    rst = 1'b1;
    a_mready = 1'b1;
    cyc();
    chk("t6_rearb_rdy", 32'(a_tready), 32'd1);
    cyc();
    chk_o("t6_first", 'h064, a_mvalid, a_mdata, 32'(a_mid));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
